muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit for the pipelined core. It sits beside the single-cycle ALU in the execute stage.
- Decodes funct3 of OP-type instructions with funct7 = 0000001 and computes one bit per cycle.
- Holds its result until the pipeline consumes it, and stalls the pipeline via busy.
- Parametrised in operand width. Handles all RISC-V M-extension corner cases in hardware.

Parameters:
- XLEN, 32, operand/result width in bits; legal values 32 and 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- kill  input  1  pipeline flush; aborts the in-flight operation
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (multiplicand/dividend)
- op_b  input  XLEN  rs2 value (multiplier/divisor)
- busy  output  1  high from the cycle after start acceptance until done
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  final result, held stable until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Accept when start=1 and kill=0. Latch funct3, op_a, op_b.
  - Compute operand signs: signed for MULH/DIV/REM; op_a signed and op_b unsigned for MULHSU; unsigned otherwise.
  - Store absolute values. Go to CALC, or to FIX if a special case applies.
- Special cases (detected at acceptance; skip CALC):
  - Divide by zero (op_b=0, funct3[2]=1): DIV/DIVU quotient = all ones; REM/REMU = op_a.
  - Signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all ones): DIV = op_a; REM = 0.
- CALC, multiply (shift-add on magnitudes):
  - 2*XLEN product register; one multiplier bit per cycle.
  - Exactly XLEN cycles; counter counts 0..XLEN-1.
- CALC, divide (restoring, on magnitudes):
  - One quotient bit per cycle; exactly XLEN cycles.
- FIX (one cycle), sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - Then select: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register result; go to DONE.
- DONE: done=1 for exactly one cycle; busy drops in the same cycle; go to IDLE. result holds.
- Latency (start accepted at edge T):
  - Normal ops: busy=1 during cycles T+1 .. T+XLEN+2; done asserted in cycle T+XLEN+2.
  - Special cases: done asserted in cycle T+2.
  - No dependence on operand values otherwise.
- start while busy: ignored; no re-latch.
- start in the DONE cycle: ignored. A new start is first accepted in the following IDLE cycle (back-to-back issue rate is one op per XLEN+3 cycles).
- kill:
  - In CALC/FIX/DONE: next state IDLE, busy=0, done=0. result keeps its previous value and is not updated.
  - kill together with start in IDLE: start is not accepted.
- Widths: no truncation before FIX. Magnitude of most-negative operand is represented as an unsigned XLEN value (no overflow).

Test Plan:
- XLEN=32, MUL/MULH/MULHSU/MULHU with op_a=op_b=0xFFFFFFFF -> results 0x00000001 / 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE; each done exactly at T+34, busy high T+1..T+34.
- DIV and REM, op_a=0xFFFFFFF9 (-7), op_b=2 -> 0xFFFFFFFD (-3) and 0xFFFFFFFF (-1). DIVU and REMU with the same operands -> 0x7FFFFFFC and 0x00000001.
- Divide by zero, op_a=5, op_b=0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> 0x00000005. done at T+2.
- Overflow, op_a=0x80000000, op_b=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0x00000000, done at T+2. DIVU with the same operands -> 0x00000000, normal latency.
- Accept MUL 3*4. Pulse start with different operands at T+5 -> ignored. Pulse kill at T+10 -> busy=0 at T+11, no done, result unchanged. A new MUL 6*7 then completes with 42.
- Assert reset asynchronously mid-CALC (between clock edges) -> busy, done, result go to 0 immediately. After release, MULHU 0xFFFFFFFF*2 -> 0x00000001. Repeat this scenario with XLEN=64.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// ============================================================================
// muldiv_unit_if : request/response bundle between the execute stage and muldiv_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, kill, funct3, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, funct3, op_a, op_b,
      output busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative RV32M/RV64M multiply/divide, one bit per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  wire logic      clk,
   input  wire logic      reset,
   muldiv_unit_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;
   logic [2:0]          funct3_q, funct3_d;
   logic                neg_a_q, neg_a_d;
   logic                neg_b_q, neg_b_d;
   logic                special_q, special_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]     mag_a, mag_b;
   logic [XLEN:0]       mul_sum, div_hi;
   logic [XLEN-1:0]     div_sub, quo_fix, rem_fix;
   logic                div_ge;
   logic [2*XLEN-1:0]   prod_fix, mul_next, div_next;
   logic [XLEN-1:0]     fix_res;

   always_comb begin
      a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      a_neg    = a_signed && bus.op_a[XLEN-1];
      b_neg    = b_signed && bus.op_b[XLEN-1];
      // Negating the most-negative value wraps back to itself, which is its correct unsigned magnitude
      mag_a    = a_neg ? -bus.op_a : bus.op_a;
      mag_b    = b_neg ? -bus.op_b : bus.op_b;
      div_zero = bus.funct3[2] && (bus.op_b == '0);
      div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.op_a == INT_MIN) && (bus.op_b == ONES);

      // Multiply: acc = {partial, remaining multiplier bits}, shifted right each step
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      mul_next = {mul_sum, acc_q[XLEN-1:1]};

      // Divide: acc = {remainder, dividend/quotient}, shifted left each step
      div_hi   = acc_q[2*XLEN-1:XLEN-1];
      div_ge   = div_hi >= {1'b0, opnd_q};
      div_sub  = div_hi[XLEN-1:0] - opnd_q;
      div_next = {(div_ge ? div_sub : div_hi[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

      case (funct3_q)
         3'b000:                 fix_res = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_res = quo_fix;
         default:                fix_res = rem_fix;
      endcase
      if (special_q) begin
         fix_res = acc_q[XLEN-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      funct3_d  = funct3_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      special_d = special_q;
      result_d  = result_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start && !bus.kill) begin
               funct3_d  = bus.funct3;
               neg_a_d   = a_neg;
               neg_b_d   = b_neg;
               cnt_d     = '0;
               special_d = div_zero || div_ovf;
               // Special cases park their final value in the low half and bypass sign fix-up
               if (div_zero) begin
                  acc_d   = {{XLEN{1'b0}}, (bus.funct3[1] ? bus.op_a : ONES)};
                  state_d = S_FIX;
               end else if (div_ovf) begin
                  acc_d   = {{XLEN{1'b0}}, (bus.funct3[1] ? {XLEN{1'b0}} : bus.op_a)};
                  state_d = S_FIX;
               end else begin
                  acc_d   = {{XLEN{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                  opnd_d  = bus.funct3[2] ? mag_b : mag_a;
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (bus.kill) begin
               state_d = S_IDLE;
            end else begin
               acc_d = funct3_q[2] ? div_next : mul_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN-1)) begin
                  state_d = S_FIX;
               end
            end
         end
         S_FIX: begin
            if (bus.kill) begin
               state_d = S_IDLE;
            end else begin
               result_d = fix_res;
               state_d  = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         funct3_q  <= '0;
         neg_a_q   <= 1'b0;
         neg_b_q   <= 1'b0;
         special_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         funct3_q  <= funct3_d;
         neg_a_q   <= neg_a_d;
         neg_b_q   <= neg_b_d;
         special_q <= special_d;
         result_q  <= result_d;
      end
   end

   assign bus.busy   = (state_q != S_IDLE);
   assign bus.done   = (state_q == S_DONE) && !bus.kill;
   assign bus.result = result_q;
endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vectors for muldiv_unit at XLEN=32 and XLEN=64
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) b32 ();
   muldiv_unit_if #(.XLEN(64)) b64 ();

   muldiv_unit #(.XLEN(32)) dut32 (.clk(clk), .reset(reset), .bus(b32.slave));
   muldiv_unit #(.XLEN(64)) dut64 (.clk(clk), .reset(reset), .bus(b64.slave));

   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit wide, input logic s, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b);
      if (wide) begin
         b64.start = s; b64.funct3 = f3; b64.op_a = a; b64.op_b = b;
      end else begin
         b32.start = s; b32.funct3 = f3; b32.op_a = a[31:0]; b32.op_b = b[31:0];
      end
   endtask

   function automatic logic obs_busy(input bit wide);
      return wide ? b64.busy : b32.busy;
   endfunction

   function automatic logic obs_done(input bit wide);
      return wide ? b64.done : b32.done;
   endfunction

   function automatic logic [63:0] obs_res(input bit wide);
      return wide ? b64.result : {32'h0, b32.result};
   endfunction

   // Issue one op (accepted at edge T), then count cycles until done
   task automatic run_op(input string tag, input bit wide, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
      int lat = 0;
      bit busy_ok = 1'b1;
      set_in(wide, 1'b1, f3, a, b);
      tick();
      set_in(wide, 1'b0, f3, a, b);
      for (int k = 1; k <= 80; k++) begin
         if (!obs_busy(wide)) busy_ok = 1'b0;
         if (obs_done(wide)) begin
            lat = k;
            break;
         end
         tick();
      end
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " result"}, obs_res(wide), exp);
      check({tag, " busy held"}, 64'(busy_ok), 64'd1);
      tick();
      check({tag, " busy after"}, 64'(obs_busy(wide)), 64'd0);
      check({tag, " done after"}, 64'(obs_done(wide)), 64'd0);
      check({tag, " result held"}, obs_res(wide), exp);
   endtask

   initial begin
      int dones;
      reset = 1'b1;
      b32.kill = 1'b0;
      b64.kill = 1'b0;
      set_in(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      set_in(1'b1, 1'b0, 3'd0, 64'd0, 64'd0);
      tick();
      tick();
      check("reset busy", 64'(b32.busy), 64'd0);
      check("reset done", 64'(b32.done), 64'd0);
      check("reset result", 64'(b32.result), 64'd0);
      reset = 1'b0;
      tick();

      run_op("mul",    1'b0, 3'b000, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 34);
      run_op("mulh",   1'b0, 3'b001, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 34);
      run_op("mulhsu", 1'b0, 3'b010, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 34);
      run_op("mulhu",  1'b0, 3'b011, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 34);
      run_op("div",    1'b0, 3'b100, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 34);
      run_op("rem",    1'b0, 3'b110, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 34);
      run_op("divu",   1'b0, 3'b101, 64'hFFFFFFF9, 64'd2, 64'h7FFFFFFC, 34);
      run_op("remu",   1'b0, 3'b111, 64'hFFFFFFF9, 64'd2, 64'h00000001, 34);
      run_op("div0",   1'b0, 3'b100, 64'd5, 64'd0, 64'hFFFFFFFF, 2);
      run_op("divu0",  1'b0, 3'b101, 64'd5, 64'd0, 64'hFFFFFFFF, 2);
      run_op("rem0",   1'b0, 3'b110, 64'd5, 64'd0, 64'h00000005, 2);
      run_op("remu0",  1'b0, 3'b111, 64'd5, 64'd0, 64'h00000005, 2);
      run_op("divovf", 1'b0, 3'b100, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 2);
      run_op("divuovf",1'b0, 3'b101, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 34);
      run_op("removf", 1'b0, 3'b110, 64'h80000000, 64'hFFFFFFFF, 64'h00000000, 2);
      run_op("rem17",  1'b0, 3'b111, 64'd17, 64'd6, 64'd5, 34);

      // Kill: MUL 3*4 accepted at T, stray start at T+5, kill sampled at T+11
      set_in(1'b0, 1'b1, 3'b000, 64'd3, 64'd4);
      tick();                                    // cycle T+1
      set_in(1'b0, 1'b0, 3'b000, 64'd3, 64'd4);
      repeat (3) tick();                         // cycle T+4
      set_in(1'b0, 1'b1, 3'b011, 64'd100, 64'd200);
      tick();                                    // cycle T+5
      set_in(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
      check("kill busy T+5", 64'(b32.busy), 64'd1);
      repeat (5) tick();                         // cycle T+10
      b32.kill = 1'b1;
      tick();                                    // cycle T+11
      b32.kill = 1'b0;
      check("kill busy T+11", 64'(b32.busy), 64'd0);
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (b32.done) dones++;
         tick();
      end
      check("kill no done", 64'(dones), 64'd0);
      check("kill result kept", 64'(b32.result), 64'd5);
      run_op("mul42", 1'b0, 3'b000, 64'd6, 64'd7, 64'd42, 34);

      // Asynchronous reset mid-CALC, XLEN=32
      set_in(1'b0, 1'b1, 3'b011, 64'hFFFFFFFF, 64'd2);
      tick();
      set_in(1'b0, 1'b0, 3'b000, 64'd0, 64'd0);
      repeat (5) tick();
      #3 reset = 1'b1;
      #1;
      check("areset32 busy", 64'(b32.busy), 64'd0);
      check("areset32 done", 64'(b32.done), 64'd0);
      check("areset32 result", 64'(b32.result), 64'd0);
      tick();
      #2 reset = 1'b0;
      tick();
      run_op("mulhu32 post", 1'b0, 3'b011, 64'hFFFFFFFF, 64'd2, 64'h1, 34);

      // Same scenario at XLEN=64
      run_op("mul64", 1'b1, 3'b000, 64'd6, 64'd7, 64'd42, 66);
      set_in(1'b1, 1'b1, 3'b011, 64'hFFFFFFFF_FFFFFFFF, 64'd2);
      tick();
      set_in(1'b1, 1'b0, 3'b000, 64'd0, 64'd0);
      repeat (7) tick();
      #3 reset = 1'b1;
      #1;
      check("areset64 busy", 64'(b64.busy), 64'd0);
      check("areset64 done", 64'(b64.done), 64'd0);
      check("areset64 result", b64.result, 64'd0);
      tick();
      #2 reset = 1'b0;
      tick();
      run_op("mulhu64 post", 1'b1, 3'b011, 64'hFFFFFFFF_FFFFFFFF, 64'd2, 64'h1, 66);
      run_op("div64", 1'b1, 3'b100, 64'hFFFFFFFF_FFFFFFF9, 64'd2, 64'hFFFFFFFF_FFFFFFFD, 66);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
